pipeline_perf_monitor: RTL and testbench

//   Synthesizable per-cycle event monitor for the pipelined CPU. It replaces the

---
 rtl/pipeline_perf_monitor_if.sv | 30 +++
 rtl/pipeline_perf_monitor.sv | 162 ++++++++++++++++
 tb/tb_pipeline_perf_monitor.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_perf_monitor_if.sv
// Snapshot stream port of the performance monitor: valid/ready word stream
// carrying one counter value per beat together with its index and a last flag.
interface pipeline_perf_monitor_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned IDX_W = 3
);
    logic             valid;
    logic             ready;
    logic [CNT_W-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;

    // Producer side (the monitor)
    modport master (
        output valid,
        output data,
        output idx,
        output last,
        input  ready
    );

    // Consumer side
    modport slave (
        input  valid,
        input  data,
        input  idx,
        input  last,
        output ready
    );
endinterface

// File: rtl/pipeline_perf_monitor.sv
// Per-cycle event monitor for the pipelined CPU: counts run cycles and
// NUM_EVT event strobes inside a bounded run window, keeps sticky overflow
// flags, and streams an atomic snapshot of all counters on request.
module pipeline_perf_monitor #(
    parameter int unsigned NUM_EVT    = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 64,
    parameter int unsigned SATURATE   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic [NUM_EVT-1:0]       evt_i,
    input  logic                     snap_req_i,
    output logic                     snap_busy_o,
    pipeline_perf_monitor_if.master  dout_if,
    output logic [CNT_W-1:0]         cycle_o,
    output logic                     done_o,
    output logic [NUM_EVT:0]         ovf_o
);
    localparam int unsigned IDX_W = $clog2(NUM_EVT + 1);
    localparam int unsigned NUM_C = NUM_EVT + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic             done_q;

    // Entry 0 is the cycle counter, entry k+1 is event k
    logic [CNT_W-1:0] cnt_q    [NUM_C];
    logic [CNT_W-1:0] cnt_d    [NUM_C];
    logic [CNT_W-1:0] shadow_q [NUM_C];
    logic [NUM_EVT:0] ovf_q;
    logic [NUM_EVT:0] ovf_d;

    logic             busy_q;
    logic             valid_q;
    logic             last_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] data_q;

    logic [NUM_EVT:0] ev_vec;
    logic             count_en;
    logic             hit_max;
    logic             snap_acc;
    logic             beat;
    logic [IDX_W-1:0] idx_nxt;

    // Counter increment with saturate/wrap, sticky overflow and window end detect
    always_comb begin
        ev_vec   = {evt_i, 1'b1};
        count_en = (state_q == S_RUN) && start_i;
        ovf_d    = ovf_q;
        for (int unsigned k = 0; k < NUM_C; k++) begin
            cnt_d[k] = cnt_q[k];
            if (count_en && ev_vec[k]) begin
                if (&cnt_q[k]) begin
                    ovf_d[k] = 1'b1;
                    cnt_d[k] = (SATURATE != 0) ? cnt_q[k] : '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
        hit_max  = count_en && (MAX_CYCLES != 0) &&
                   (64'(cnt_d[0]) == 64'(MAX_CYCLES));
        snap_acc = snap_req_i && !busy_q;
        beat     = valid_q && dout_if.ready;
        idx_nxt  = idx_q + IDX_W'(1);
    end

    // Run-window FSM, counters, snapshot shadows and stream registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            ovf_q   <= '0;
            for (int unsigned k = 0; k < NUM_C; k++) begin
                cnt_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else if (clear_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            ovf_q   <= '0;
            for (int unsigned k = 0; k < NUM_C; k++) begin
                cnt_q[k] <= '0;
            end
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (hit_max) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase

            // Shadows capture the pre-edge counters so the request cycle is excluded
            if (snap_acc) begin
                shadow_q <= cnt_q;
                busy_q   <= 1'b1;
                valid_q  <= 1'b1;
                idx_q    <= '0;
                data_q   <= cnt_q[0];
                last_q   <= (NUM_EVT == 0);
            end else if (beat) begin
                if (last_q) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    idx_q   <= '0;
                    data_q  <= '0;
                end else begin
                    idx_q  <= idx_nxt;
                    data_q <= shadow_q[idx_nxt];
                    last_q <= (idx_nxt == IDX_W'(NUM_EVT));
                end
            end
        end
    end

    assign snap_busy_o   = busy_q;
    assign dout_if.valid = valid_q;
    assign dout_if.data  = data_q;
    assign dout_if.idx   = idx_q;
    assign dout_if.last  = last_q;
    assign cycle_o       = cnt_q[0];
    assign done_o        = done_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench for pipeline_perf_monitor: a default 32-bit instance plus
// two 4-bit instances (saturating and wrapping) sharing the same stimulus.
module tb_pipeline_perf_monitor;
    localparam int unsigned NE = 4;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [NE-1:0] evt = '0;
    logic          snap = 1'b0;
    logic          ready = 1'b0;

    logic          m_busy, s_busy, w_busy;
    logic [31:0]   m_cyc;
    logic [3:0]    s_cyc, w_cyc;
    logic          m_done, s_done, w_done;
    logic [NE:0]   m_ovf, s_ovf, w_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_perf_monitor_if #(.CNT_W(32), .IDX_W(IW)) m_if ();
    pipeline_perf_monitor_if #(.CNT_W(4),  .IDX_W(IW)) s_if ();
    pipeline_perf_monitor_if #(.CNT_W(4),  .IDX_W(IW)) w_if ();

    assign m_if.ready = ready;
    assign s_if.ready = ready;
    assign w_if.ready = ready;

    always #5 clk = ~clk;

    pipeline_perf_monitor #(.NUM_EVT(NE), .CNT_W(32), .MAX_CYCLES(64), .SATURATE(1)) u_main (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
        .snap_req_i(snap), .snap_busy_o(m_busy), .dout_if(m_if.master),
        .cycle_o(m_cyc), .done_o(m_done), .ovf_o(m_ovf));

    pipeline_perf_monitor #(.NUM_EVT(NE), .CNT_W(4), .MAX_CYCLES(64), .SATURATE(1)) u_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
        .snap_req_i(snap), .snap_busy_o(s_busy), .dout_if(s_if.master),
        .cycle_o(s_cyc), .done_o(s_done), .ovf_o(s_ovf));

    pipeline_perf_monitor #(.NUM_EVT(NE), .CNT_W(4), .MAX_CYCLES(64), .SATURATE(0)) u_wrap (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
        .snap_req_i(snap), .snap_busy_o(w_busy), .dout_if(w_if.master),
        .cycle_o(w_cyc), .done_o(w_done), .ovf_o(w_ovf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1;
        tick(); tick();
        n_cmp++; if (m_cyc !== 32'd0) begin n_bad++; $display("FAIL reset_cycle got %0d want 0", m_cyc); end
        n_cmp++; if ({m_done, m_busy, m_if.valid, m_if.last} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_flags got %b want 0000", {m_done, m_busy, m_if.valid, m_if.last}); end
        n_cmp++; if ({m_if.idx, m_if.data, m_ovf} !== '0) begin n_bad++;
            $display("FAIL reset_stream idx=%0d data=%0d ovf=%b want all 0", m_if.idx, m_if.data, m_ovf); end
        n_cmp++; if ({s_ovf, s_cyc, w_ovf, w_cyc} !== '0) begin n_bad++;
            $display("FAIL reset_small got s=%0d/%b w=%0d/%b want 0", s_cyc, s_ovf, w_cyc, w_ovf); end
        rst = 1'b1; start = 1'b0;
        tick();
        n_cmp++; if (m_cyc !== 32'd0) begin n_bad++; $display("FAIL idle_hold got %0d want 0", m_cyc); end
    endtask

    task automatic test_run_window();
        logic [31:0] exp_w [5];
        start = 1'b1;
        tick();
        n_cmp++; if (m_cyc !== 32'd0) begin n_bad++; $display("FAIL start_nocount got %0d want 0", m_cyc); end
        for (int n = 1; n <= 64; n++) begin
            evt = (n >= 10 && n <= 12) ? 4'b0001 : 4'b0000;
            tick();
            if (n == 63) begin
                n_cmp++; if (m_done !== 1'b0) begin n_bad++; $display("FAIL done_early got %b want 0", m_done); end
            end
        end
        evt = '0;
        n_cmp++; if ({m_done, m_cyc} !== {1'b1, 32'd64}) begin n_bad++;
            $display("FAIL window_end done=%b cyc=%0d want 1/64", m_done, m_cyc); end
        repeat (20) tick();
        n_cmp++; if ({m_done, m_cyc} !== {1'b1, 32'd64}) begin n_bad++;
            $display("FAIL frozen done=%b cyc=%0d want 1/64", m_done, m_cyc); end
        exp_w[0] = 32'd64; exp_w[1] = 32'd3; exp_w[2] = 32'd0; exp_w[3] = 32'd0; exp_w[4] = 32'd0;
        snap = 1'b1; tick(); snap = 1'b0; ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            n_cmp++;
            if ({m_if.valid, m_if.idx, m_if.data, m_if.last} !== {1'b1, IW'(w), exp_w[w], (w == 4)}) begin
                n_bad++;
                $display("FAIL run_word%0d got v=%b i=%0d d=%0d l=%b want 1/%0d/%0d/%b",
                         w, m_if.valid, m_if.idx, m_if.data, m_if.last, w, exp_w[w], (w == 4));
            end
            tick();
        end
        n_cmp++; if ({m_if.valid, m_busy} !== 2'b00) begin n_bad++;
            $display("FAIL run_stream_end got %b want 00", {m_if.valid, m_busy}); end
        ready = 1'b0;
    endtask

    task automatic test_pause();
        clear = 1'b1; tick(); clear = 1'b0;
        n_cmp++; if ({m_done, m_cyc} !== {1'b0, 32'd0}) begin n_bad++;
            $display("FAIL pause_clear done=%b cyc=%0d want 0/0", m_done, m_cyc); end
        start = 1'b1; tick();
        repeat (30) tick();
        n_cmp++; if (m_cyc !== 32'd30) begin n_bad++; $display("FAIL pause_pre got %0d want 30", m_cyc); end
        start = 1'b0;
        repeat (5) tick();
        n_cmp++; if ({m_done, m_cyc} !== {1'b0, 32'd30}) begin n_bad++;
            $display("FAIL pause_hold done=%b cyc=%0d want 0/30", m_done, m_cyc); end
        start = 1'b1;
        repeat (33) tick();
        n_cmp++; if ({m_done, m_cyc} !== {1'b0, 32'd63}) begin n_bad++;
            $display("FAIL pause_63 done=%b cyc=%0d want 0/63", m_done, m_cyc); end
        tick();
        n_cmp++; if ({m_done, m_cyc} !== {1'b1, 32'd64}) begin n_bad++;
            $display("FAIL pause_done done=%b cyc=%0d want 1/64", m_done, m_cyc); end
    endtask

    task automatic test_snapshot();
        logic [31:0] exp_w [5];
        int w;
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick();
        evt = 4'b0010;
        repeat (20) tick();
        n_cmp++; if (m_cyc !== 32'd20) begin n_bad++; $display("FAIL snap_pre got %0d want 20", m_cyc); end
        exp_w[0] = 32'd20; exp_w[1] = 32'd0; exp_w[2] = 32'd20; exp_w[3] = 32'd0; exp_w[4] = 32'd0;
        snap = 1'b1; tick(); snap = 1'b0;
        w = 0;
        for (int s = 0; s < 20 && w < 5; s++) begin
            ready = (s % 2 == 0);
            n_cmp++;
            if ({m_busy, m_if.valid, m_if.idx, m_if.data, m_if.last} !==
                {1'b1, 1'b1, IW'(w), exp_w[w], (w == 4)}) begin
                n_bad++;
                $display("FAIL snap_step%0d got v=%b i=%0d d=%0d l=%b want 1/%0d/%0d/%b",
                         s, m_if.valid, m_if.idx, m_if.data, m_if.last, w, exp_w[w], (w == 4));
            end
            tick();
            if (ready) w++;
        end
        ready = 1'b0;
        n_cmp++; if (w != 5) begin n_bad++; $display("FAIL snap_timeout got %0d words want 5", w); end
        n_cmp++; if ({m_if.valid, m_busy} !== 2'b00) begin n_bad++;
            $display("FAIL snap_end got %b want 00", {m_if.valid, m_busy}); end
        n_cmp++; if (m_cyc !== 32'd30) begin n_bad++; $display("FAIL snap_live got %0d want 30", m_cyc); end
        snap = 1'b1; tick(); snap = 1'b0;
        n_cmp++; if ({m_busy, m_if.valid, m_if.idx, m_if.data} !== {1'b1, 1'b1, IW'(0), 32'd30}) begin n_bad++;
            $display("FAIL b2b_first got b=%b v=%b i=%0d d=%0d want 1/1/0/30", m_busy, m_if.valid, m_if.idx, m_if.data); end
        ready = 1'b1;
        tick(); tick();
        n_cmp++; if ({m_if.idx, m_if.data} !== {IW'(2), 32'd30}) begin n_bad++;
            $display("FAIL b2b_evt1 got i=%0d d=%0d want 2/30", m_if.idx, m_if.data); end
        tick(); tick(); tick();
        n_cmp++; if ({m_if.valid, m_busy} !== 2'b00) begin n_bad++;
            $display("FAIL b2b_end got %b want 00", {m_if.valid, m_busy}); end
        ready = 1'b0; start = 1'b0; evt = '0;
    endtask

    task automatic test_saturate();
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick();
        evt = 4'b0001;
        repeat (20) tick();
        start = 1'b0; evt = '0;
        tick();
        n_cmp++; if ({s_cyc, w_cyc} !== {4'd15, 4'd4}) begin n_bad++;
            $display("FAIL small_cyc got sat=%0d wrap=%0d want 15/4", s_cyc, w_cyc); end
        n_cmp++; if ({s_ovf, w_ovf} !== {5'b00011, 5'b00011}) begin n_bad++;
            $display("FAIL small_ovf got sat=%b wrap=%b want 00011/00011", s_ovf, w_ovf); end
        n_cmp++; if ({m_ovf, m_cyc} !== {5'b00000, 32'd20}) begin n_bad++;
            $display("FAIL wide_noovf got ovf=%b cyc=%0d want 0/20", m_ovf, m_cyc); end
        snap = 1'b1; tick(); snap = 1'b0; ready = 1'b1;
        tick();
        n_cmp++; if ({s_if.idx, s_if.data, w_if.data} !== {IW'(1), 4'd15, 4'd4}) begin n_bad++;
            $display("FAIL small_evt0 got i=%0d sat=%0d wrap=%0d want 1/15/4", s_if.idx, s_if.data, w_if.data); end
        repeat (4) tick();
        n_cmp++; if ({s_if.valid, w_if.valid} !== 2'b00) begin n_bad++;
            $display("FAIL small_end got %b want 00", {s_if.valid, w_if.valid}); end
        ready = 1'b0;
    endtask

    task automatic test_clear_abort();
        start = 1'b1;
        repeat (3) tick();
        snap = 1'b1; tick(); snap = 1'b0; ready = 1'b1;
        tick(); tick();
        n_cmp++; if ({m_if.valid, m_if.idx} !== {1'b1, IW'(2)}) begin n_bad++;
            $display("FAIL abort_pre got v=%b i=%0d want 1/2", m_if.valid, m_if.idx); end
        clear = 1'b1; snap = 1'b1; evt = 4'b1111; ready = 1'b0;
        tick();
        clear = 1'b0; snap = 1'b0; evt = '0; start = 1'b0;
        n_cmp++; if ({m_if.valid, m_busy, m_if.last, m_if.idx} !== {3'b000, IW'(0)}) begin n_bad++;
            $display("FAIL abort_stream got v=%b b=%b l=%b i=%0d want 0", m_if.valid, m_busy, m_if.last, m_if.idx); end
        n_cmp++; if ({m_cyc, m_ovf, s_ovf, m_done} !== '0) begin n_bad++;
            $display("FAIL abort_counters cyc=%0d ovf=%b sovf=%b done=%b want 0", m_cyc, m_ovf, s_ovf, m_done); end
        tick();
        n_cmp++; if ({m_if.valid, m_busy} !== 2'b00) begin n_bad++;
            $display("FAIL abort_req_ignored got %b want 00", {m_if.valid, m_busy}); end
        start = 1'b1; tick();
        n_cmp++; if (m_cyc !== 32'd0) begin n_bad++; $display("FAIL abort_idle got %0d want 0", m_cyc); end
        tick();
        n_cmp++; if (m_cyc !== 32'd1) begin n_bad++; $display("FAIL abort_restart got %0d want 1", m_cyc); end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_window();
        test_pause();
        test_snapshot();
        test_saturate();
        test_clear_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
